// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the configuration scan-chain loader.
// The optional readback deserializer is enabled with the SCAN_READBACK_EN macro.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  localparam int WORD_W_DEF    = 8;
  localparam int CHAIN_LEN_DEF = 64;

  // Counter width able to hold the value n itself (not just n-1).
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int words_per_load(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Number of meaningful bits in the final word of a load.
  function automatic int last_bits(input int chain_len, input int word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

  localparam int CNT_W          = cnt_w(CHAIN_LEN_DEF);
  localparam int WORDS_PER_LOAD = words_per_load(CHAIN_LEN_DEF, WORD_W_DEF);
  localparam int LAST_BITS      = last_bits(CHAIN_LEN_DEF, WORD_W_DEF);

endpackage

// File: rtl/scan_piso.sv
// Parallel-in serial-out word register, MSB first, with a bit count so the
// loader can see when it is empty or about to present its final bit.
module scan_piso
  import scan_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  output logic              bit_out,
  output logic              empty,
  output logic              last
);

  localparam int PC_W = cnt_w(WORD_W);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [PC_W-1:0]   cnt_q, cnt_d;

  // Load wins over shift so a refill can land on the cycle the last bit leaves.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (load) begin
      sr_d  = load_data;
      cnt_d = PC_W'(WORD_W);
    end else if (shift && (cnt_q != '0)) begin
      sr_d  = {sr_q[WORD_W-2:0], 1'b0};
      cnt_d = cnt_q - PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_out = sr_q[WORD_W-1];
  assign empty   = (cnt_q == '0);
  assign last    = (cnt_q == PC_W'(1));

endmodule

// File: rtl/scan_chain_loader.sv
// Serializes host config words onto the scan chain head and drives scan_en.
// Define SCAN_READBACK_EN to add rb_data/rb_valid capture of the old chain content.
module scan_chain_loader
  import scan_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64
) (
  input  logic              scan_clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              chain_sdo,
  output logic              chain_en,
  input  logic              chain_sdi,
  output logic              busy,
  output logic              done
`ifdef SCAN_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int LD_CNT_W = cnt_w(CHAIN_LEN);
  localparam int WORDS    = words_per_load(CHAIN_LEN, WORD_W);
  localparam int WC_W     = cnt_w(WORDS);

  scan_state_e       state_q, state_d;
  logic [LD_CNT_W-1:0] bits_left_q, bits_left_d;
  logic [WC_W-1:0]   words_left_q, words_left_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              chain_sdo_q, chain_sdo_d;
  logic              chain_en_q, chain_en_d;

  logic              piso_clr, piso_load, piso_shift;
  logic [WORD_W-1:0] piso_data;
  logic              piso_bit, piso_empty, piso_last;
  logic              xfer, issue, piso_avail;

  scan_piso #(.WORD_W(WORD_W)) u_piso (
    .clk       (scan_clk),
    .rst       (rst),
    .clr       (piso_clr),
    .load      (piso_load),
    .load_data (piso_data),
    .shift     (piso_shift),
    .bit_out   (piso_bit),
    .empty     (piso_empty),
    .last      (piso_last)
  );

  assign word_ready = (state_q == SHIFT) && !hold_full_q && (words_left_q != '0);
  assign xfer       = word_valid && word_ready;
  assign issue      = (state_q == SHIFT) && !piso_empty;
  // The shift register can take a new word if it is empty or emptying this cycle.
  assign piso_avail = piso_empty || (issue && piso_last);

  always_comb begin
    state_d      = state_q;
    bits_left_d  = bits_left_q;
    words_left_d = words_left_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    chain_sdo_d  = chain_sdo_q;
    chain_en_d   = 1'b0;
    piso_clr     = 1'b0;
    piso_load    = 1'b0;
    piso_shift   = 1'b0;
    piso_data    = word_data;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d      = SHIFT;
          bits_left_d  = LD_CNT_W'(CHAIN_LEN);
          words_left_d = WC_W'(WORDS);
          hold_full_d  = 1'b0;
          piso_clr     = 1'b1;
        end
      end
      SHIFT: begin
        if (xfer) begin
          words_left_d = words_left_q - WC_W'(1);
        end
        if (issue) begin
          chain_en_d  = 1'b1;
          chain_sdo_d = piso_bit;
          piso_shift  = 1'b1;
          bits_left_d = bits_left_q - LD_CNT_W'(1);
        end
        // Final bit: any low bits of a partial last word are dropped here.
        if (issue && (bits_left_q == LD_CNT_W'(1))) begin
          state_d     = FLUSH;
          piso_clr    = 1'b1;
          hold_full_d = 1'b0;
        end else if (piso_avail) begin
          if (hold_full_q) begin
            piso_load   = 1'b1;
            piso_data   = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            piso_load = 1'b1;
          end
        end else if (xfer) begin
          hold_d      = word_data;
          hold_full_d = 1'b1;
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge scan_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bits_left_q  <= '0;
      words_left_q <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      chain_sdo_q  <= 1'b0;
      chain_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bits_left_q  <= bits_left_d;
      words_left_q <= words_left_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      chain_sdo_q  <= chain_sdo_d;
      chain_en_q   <= chain_en_d;
    end
  end

  assign chain_sdo = chain_sdo_q;
  assign chain_en  = chain_en_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

`ifdef SCAN_READBACK_EN
  localparam int RB_LAST = last_bits(CHAIN_LEN, WORD_W);
  localparam int RC_W    = cnt_w(WORD_W);

  logic [WORD_W-1:0]   rb_sh_q, rb_sh_d;
  logic [RC_W-1:0]     rb_cnt_q, rb_cnt_d;
  logic [LD_CNT_W-1:0] rb_left_q, rb_left_d;
  logic [WORD_W-1:0]   rb_data_q, rb_data_d;
  logic                rb_valid_q, rb_valid_d;
  logic [WORD_W-1:0]   rb_next;

  assign rb_next = {rb_sh_q[WORD_W-2:0], chain_sdi};

  // Each edge with scan_en high moves one old tail bit into the readback word.
  always_comb begin
    rb_sh_d    = rb_sh_q;
    rb_cnt_d   = rb_cnt_q;
    rb_left_d  = rb_left_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if ((state_q == IDLE) && cfg_start) begin
      rb_sh_d   = '0;
      rb_cnt_d  = '0;
      rb_left_d = LD_CNT_W'(CHAIN_LEN);
    end else if (chain_en_q) begin
      rb_sh_d   = rb_next;
      rb_left_d = rb_left_q - LD_CNT_W'(1);
      if (rb_left_q == LD_CNT_W'(1)) begin
        rb_data_d  = WORD_W'(rb_next << (WORD_W - RB_LAST));
        rb_valid_d = 1'b1;
        rb_cnt_d   = '0;
      end else if (rb_cnt_q == RC_W'(WORD_W - 1)) begin
        rb_data_d  = rb_next;
        rb_valid_d = 1'b1;
        rb_cnt_d   = '0;
      end else begin
        rb_cnt_d = rb_cnt_q + RC_W'(1);
      end
    end
  end

  always_ff @(posedge scan_clk or posedge rst) begin
    if (rst) begin
      rb_sh_q    <= '0;
      rb_cnt_q   <= '0;
      rb_left_q  <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_sh_q    <= rb_sh_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_left_q  <= rb_left_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic sdi_unused;
  assign sdi_unused = chain_sdi;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Scoreboard bench: instance 0 has a 16-bit chain, instance 1 a 12-bit chain,
// each with a behavioural model of the scan chain itself.
module tb_scan_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cfg_start  [2];
  logic [7:0] word_data  [2];
  logic       word_valid [2];
  logic       word_ready [2];
  logic       chain_sdo  [2];
  logic       chain_en   [2];
  logic       chain_sdi  [2];
  logic       busy       [2];
  logic       done       [2];
`ifdef SCAN_READBACK_EN
  logic [7:0] rb_data    [2];
  logic       rb_valid   [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    scan_chain_loader #(.WORD_W(8), .CHAIN_LEN((g == 0) ? 16 : 12)) u_dut (
      .scan_clk   (clk),
      .rst        (rst),
      .cfg_start  (cfg_start[g]),
      .word_data  (word_data[g]),
      .word_valid (word_valid[g]),
      .word_ready (word_ready[g]),
      .chain_sdo  (chain_sdo[g]),
      .chain_en   (chain_en[g]),
      .chain_sdi  (chain_sdi[g]),
      .busy       (busy[g]),
      .done       (done[g])
`ifdef SCAN_READBACK_EN
      ,
      .rb_data    (rb_data[g]),
      .rb_valid   (rb_valid[g])
`endif
    );
  end

  function automatic int cl(input int i);
    return (i == 0) ? 16 : 12;
  endfunction

  // Scan chain model: head at bit 0, tail at bit cl-1.
  logic [15:0] chain_m [2] = '{default: 16'h0};
  logic        preload_req [2];
  logic [15:0] preload_val [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (preload_req[i]) chain_m[i] <= preload_val[i];
      else if (chain_en[i]) chain_m[i] <= {chain_m[i][14:0], chain_sdo[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) chain_sdi[i] = chain_m[i][cl(i)-1];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h expected=%0h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  // Scoreboard state
  bit         exp_bits [2][64];
  int         eb_wr [2], eb_rd [2];
  logic [7:0] exp_rb [2][4];
  int         rb_wr [2], rb_rd [2];
  logic [15:0] exp_img [2];
  int hs_cnt [2], en_cnt [2], gap_cnt [2], done_cnt [2], lat [2];
  bit prev_done [2];

  // Monitor: samples 2 time units before each rising edge.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (lat[i] == 2) check("first_bit_early", i, 32'(chain_en[i]), 32'd0);
        if (lat[i] == 1) check("first_bit_latency", i, 32'(chain_en[i]), 32'd1);
        if (lat[i] > 0) lat[i]--;
        if (word_valid[i] && word_ready[i]) begin
          hs_cnt[i]++;
          if (hs_cnt[i] > 2) check("extra_word_accepted", i, 32'(hs_cnt[i]), 32'd2);
          if (hs_cnt[i] == 1 && en_cnt[i] == 0) lat[i] = 2;
        end
        if (chain_en[i]) begin
          if (eb_rd[i] < eb_wr[i]) begin
            check("chain_sdo_bit", i, 32'(chain_sdo[i]), 32'(exp_bits[i][eb_rd[i]]));
            eb_rd[i]++;
          end else begin
            check("unexpected_chain_en", i, 32'd1, 32'd0);
          end
          en_cnt[i]++;
        end else if (busy[i] && en_cnt[i] > 0 && en_cnt[i] < cl(i)) begin
          gap_cnt[i]++;
        end
`ifdef SCAN_READBACK_EN
        if (rb_valid[i]) begin
          if (rb_rd[i] < rb_wr[i]) begin
            check("rb_data", i, 32'(rb_data[i]), 32'(exp_rb[i][rb_rd[i]]));
            rb_rd[i]++;
          end else begin
            check("unexpected_rb_valid", i, 32'd1, 32'd0);
          end
        end
`endif
        if (prev_done[i]) check("busy_after_done", i, 32'(busy[i]), 32'd0);
        if (done[i]) begin
          done_cnt[i]++;
          check("done_en_cycles", i, 32'(en_cnt[i]), 32'(cl(i)));
          check("done_busy", i, 32'(busy[i]), 32'd1);
          check("done_handshakes", i, 32'(hs_cnt[i]), 32'd2);
          check("done_bits_left", i, 32'(eb_wr[i] - eb_rd[i]), 32'd0);
          check("chain_image", i, 32'(chain_m[i] & 16'((32'd1 << cl(i)) - 1)), 32'(exp_img[i]));
`ifdef SCAN_READBACK_EN
          check("rb_word_count", i, 32'(rb_rd[i]), 32'(rb_wr[i]));
`endif
        end
        prev_done[i] = done[i];
      end
    end
  end

  task automatic preload(input int i, input logic [15:0] v);
    @(posedge clk); #1;
    preload_val[i] = v;
    preload_req[i] = 1'b1;
    @(posedge clk); #1;
    preload_req[i] = 1'b0;
  endtask

  // Reference model: the chain receives the concatenated words MSB first,
  // truncated to the chain length; readback returns the old chain tail-first.
  task automatic prep(input int i, input logic [7:0] w0, input logic [7:0] w1);
    logic [15:0] cat, old;
    int n;
    n   = cl(i);
    cat = {w0, w1};
    for (int k = 0; k < n; k++) exp_bits[i][k] = cat[15-k];
    eb_rd[i]   = 0;
    eb_wr[i]   = n;
    exp_img[i] = cat >> (16 - n);
    old = chain_m[i] << (16 - n);
    exp_rb[i][0] = old[15:8];
    exp_rb[i][1] = old[7:0];
    rb_rd[i] = 0;
    rb_wr[i] = 2;
    hs_cnt[i]  = 0;
    en_cnt[i]  = 0;
    gap_cnt[i] = 0;
    lat[i]     = 0;
  endtask

  task automatic start_pulse(input int i);
    @(posedge clk); #1;
    cfg_start[i] = 1'b1;
    @(posedge clk); #1;
    cfg_start[i] = 1'b0;
  endtask

  task automatic send_word(input int i, input logic [7:0] w);
    int budget;
    word_data[i]  = w;
    word_valid[i] = 1'b1;
    budget = 0;
    while (!word_ready[i] && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 100) check("handshake_timeout", i, 32'd0, 32'd1);
    @(posedge clk); #1;
    word_valid[i] = 1'b0;
  endtask

  // mode 0: back-to-back, 1: random idle gaps, 2: second word held back until
  // the first word has fully shifted out plus two cycles.
  task automatic run_load(input int i, input logic [7:0] w0, input logic [7:0] w1,
                          input int mode, input bit restart, input bit extra,
                          input int exp_gap);
    logic [7:0] w [2];
    int base_done, budget;
    w[0] = w0;
    w[1] = w1;
    prep(i, w0, w1);
    base_done = done_cnt[i];
    start_pulse(i);
    for (int k = 0; k < 2; k++) begin
      if (mode == 1) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if (mode == 2 && k == 1) begin
        budget = 0;
        while (en_cnt[i] < 8 && budget < 100) begin @(posedge clk); #1; budget++; end
        @(posedge clk); #1;
      end
      send_word(i, w[k]);
      cfg_start[i] = 1'b0;
      if (restart && k == 0) cfg_start[i] = 1'b1;
    end
    if (extra) begin
      word_data[i]  = 8'h55;
      word_valid[i] = 1'b1;
    end
    budget = 0;
    while (done_cnt[i] == base_done && budget < 200) begin @(posedge clk); #1; budget++; end
    if (done_cnt[i] == base_done) check("done_timeout", i, 32'd0, 32'd1);
    word_valid[i] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("done_pulses", i, 32'(done_cnt[i] - base_done), 32'd1);
    check("idle_busy", i, 32'(busy[i]), 32'd0);
    if (exp_gap >= 0) check("stall_gap", i, 32'(gap_cnt[i]), 32'(exp_gap));
  endtask

  initial begin
    int budget, inst;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cfg_start[i]   = 1'b0;
      word_data[i]   = 8'h00;
      word_valid[i]  = 1'b0;
      preload_req[i] = 1'b0;
      preload_val[i] = 16'h0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_chain_en", i, 32'(chain_en[i]), 32'd0);
      check("reset_chain_sdo", i, 32'(chain_sdo[i]), 32'd0);
      check("reset_word_ready", i, 32'(word_ready[i]), 32'd0);
      check("reset_busy_done", i, {30'd0, busy[i], done[i]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_load(0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0, 0);
    run_load(0, 8'hA5, 8'h3C, 2, 1'b0, 1'b0, 3);
    run_load(1, 8'hFF, 8'hA0, 0, 1'b0, 1'b1, 0);
    run_load(0, 8'h96, 8'h0F, 0, 1'b1, 1'b0, 0);
    preload(0, 16'h1234);
    run_load(0, 8'hFF, 8'hFF, 0, 1'b0, 1'b0, 0);

    // Asynchronous reset in the middle of a load.
    prep(0, 8'hC3, 8'h5A);
    start_pulse(0);
    send_word(0, 8'hC3);
    budget = 0;
    while (en_cnt[0] < 5 && budget < 100) begin @(posedge clk); #1; budget++; end
    #2 rst = 1'b1;
    #1;
    check("abort_chain_en", 0, 32'(chain_en[0]), 32'd0);
    check("abort_busy", 0, 32'(busy[0]), 32'd0);
    check("abort_word_ready", 0, 32'(word_ready[0]), 32'd0);
    eb_rd[0] = eb_wr[0];
    rb_rd[0] = rb_wr[0];
    lat[0] = 0;
    prev_done[0] = 1'b0;
    #3 rst = 1'b0;
    run_load(0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0, 0);

    for (int t = 0; t < 16; t++) begin
      inst = int'($urandom_range(0, 1));
      if ((t % 4) == 0) preload(inst, 16'($urandom));
      run_load(inst, 8'($urandom), 8'($urandom), ((t % 3) == 0) ? 0 : 1, 1'b0,
               1'($urandom_range(0, 1)), ((t % 3) == 0) ? 0 : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
